// File: rtl/mdu_sequencer_if.sv
// Handshake/data bundle between a requester (master) and the mdu_sequencer (slave).
interface mdu_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       func3;
   logic [WIDTH-1:0] operand_a;
   logic [WIDTH-1:0] operand_b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;

   modport master (
      output start, func3, operand_a, operand_b,
      input  busy, done, result
   );

   modport slave (
      input  start, func3, operand_a, operand_b,
      output busy, done, result
   );
endinterface

// File: rtl/mdu_sequencer.sv
// Iterative multiply/divide sequencer: shift-add multiply, restoring divide, one bit per cycle.
// Defining MDU_EARLY_OUT_EN lets zero-multiply, divide-by-zero and signed overflow skip the loop.
module mdu_sequencer #(
   parameter int WIDTH = 32
) (
   input logic            clk,
   input logic            reset,
   mdu_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, FINISH} state_t;

   localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t             state;
   logic [CW-1:0]      cnt;
   logic [2:0]         op;
   logic               neg_a;
   logic               neg_b;
   logic               div_zero;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;
   logic               busy;
   logic               done;
   logic [WIDTH-1:0]   result;

   logic               a_signed;
   logic               b_signed;
   logic               in_neg_a;
   logic               in_neg_b;
   logic               in_div_zero;
   logic               skip;
   logic [WIDTH-1:0]   in_mag_a;
   logic [WIDTH-1:0]   in_mag_b;
   logic [2*WIDTH-1:0] acc_init;
   logic [2*WIDTH-1:0] acc_step;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH-1:0]   div_diff;
   logic [WIDTH-1:0]   fin_step;
   logic [WIDTH-1:0]   fin_hold;

   // acc holds {hi, lo} of the product, or {remainder, dividend/quotient} for divides.
   function automatic logic [WIDTH-1:0] finalize(input logic [2*WIDTH-1:0] v);
      logic [2*WIDTH-1:0] prod;
      logic [WIDTH-1:0]   quo;
      logic [WIDTH-1:0]   rem;
      prod = (neg_a ^ neg_b) ? ('0 - v) : v;
      quo  = div_zero ? '1 : ((neg_a ^ neg_b) ? ('0 - v[WIDTH-1:0]) : v[WIDTH-1:0]);
      rem  = neg_a ? ('0 - v[2*WIDTH-1:WIDTH]) : v[2*WIDTH-1:WIDTH];
      if (!op[2])
         return (op[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      return op[1] ? rem : quo;
   endfunction

   always_comb begin
      a_signed    = bus.func3[2] ? ~bus.func3[0] : (bus.func3[1:0] != 2'b11);
      b_signed    = bus.func3[2] ? ~bus.func3[0] : ~bus.func3[1];
      in_neg_a    = a_signed & bus.operand_a[WIDTH-1];
      in_neg_b    = b_signed & bus.operand_b[WIDTH-1];
      in_mag_a    = in_neg_a ? ('0 - bus.operand_a) : bus.operand_a;
      in_mag_b    = in_neg_b ? ('0 - bus.operand_b) : bus.operand_b;
      in_div_zero = (bus.operand_b == '0);
      acc_init    = bus.func3[2] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
      skip        = 1'b0;
`ifdef MDU_EARLY_OUT_EN
      // Preload acc so FINISH's normal sign correction yields the special-case result.
      if (bus.func3[2]) begin
         if (in_div_zero) begin
            skip     = 1'b1;
            acc_init = {in_mag_a, {WIDTH{1'b1}}};
         end else if (a_signed && in_neg_b && (in_mag_b == WIDTH'(1)) &&
                      (bus.operand_a == {1'b1, {(WIDTH-1){1'b0}}})) begin
            skip = 1'b1;
         end
      end else if ((bus.operand_a == '0) || (bus.operand_b == '0)) begin
         skip     = 1'b1;
         acc_init = '0;
      end
`endif
   end

   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
      div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff  = div_shift[WIDTH-1:0] - mag_b;
      if (state == MUL)
         acc_step = {mul_sum, acc[WIDTH-1:1]};
      else if (div_shift >= {1'b0, mag_b})
         acc_step = {div_diff, acc[WIDTH-2:0], 1'b1};
      else
         acc_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      fin_step = finalize(acc_step);
      fin_hold = finalize(acc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         op       <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         div_zero <= 1'b0;
         mag_a    <= '0;
         mag_b    <= '0;
         acc      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         result   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op       <= bus.func3;
                  neg_a    <= in_neg_a;
                  neg_b    <= in_neg_b;
                  div_zero <= in_div_zero;
                  mag_a    <= in_mag_a;
                  mag_b    <= in_mag_b;
                  acc      <= acc_init;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= skip ? FINISH : (bus.func3[2] ? DIV : MUL);
               end
            end
            MUL, DIV: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
               // The loop's last edge lands the corrected result so done is visible throughout FINISH.
               if (cnt == LAST) begin
                  state  <= FINISH;
                  done   <= 1'b1;
                  result <= fin_step;
               end
            end
            FINISH: begin
               if (done) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  done   <= 1'b1;
                  result <= fin_hold;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = busy;
   assign bus.done   = done;
   assign bus.result = result;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Randomised and directed bench for mdu_sequencer against a cycle-count/arithmetic reference model.
module tb_mdu_sequencer;
   localparam int W = 32;
`ifdef MDU_EARLY_OUT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mdu_sequencer_if #(.WIDTH(W)) bus ();
   mdu_sequencer #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint     sa;
      longint     sb;
      logic [63:0] ua;
      logic [63:0] ub;
      logic [63:0] p;
      bit          ovf;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         3'd0: begin p = 64'(sa * sb);          return p[31:0];  end
         3'd1: begin p = 64'(sa * sb);          return p[63:32]; end
         3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
         3'd3: begin p = ua * ub;               return p[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (ovf) return a;
            p = 64'(sa / sb);
            return p[31:0];
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (ovf) return 32'd0;
            p = 64'(sa % sb);
            return p[31:0];
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic bit model_fast(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      if (!EARLY) return 1'b0;
      if (!f[2]) return (a == 0) || (b == 0);
      return (b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   // Reference: done appears W edges after acceptance (1 for early-out) and lasts one cycle.
   bit          model_live = 1'b0;
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   int          m_left = 0;
   logic [31:0] m_result = '0;
   logic [31:0] m_pend = '0;

   always @(posedge clk) begin
      model_live = 1'b1;
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_left = 0; m_result = '0;
      end else if (!m_busy) begin
         if (bus.start) begin
            m_busy = 1'b1;
            m_pend = model_result(bus.func3, bus.operand_a, bus.operand_b);
            m_left = model_fast(bus.func3, bus.operand_a, bus.operand_b) ? 1 : W;
         end
      end else if (m_done) begin
         m_done = 1'b0; m_busy = 1'b0;
      end else begin
         m_left--;
         if (m_left == 0) begin
            m_done = 1'b1; m_result = m_pend;
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         chk("busy", 32'(bus.busy), 32'(m_busy));
         chk("done", 32'(bus.done), 32'(m_done));
         chk("result", bus.result, m_result);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (bus.busy !== 1'b0 && n < 200) begin
         @(posedge clk); #1; n++;
      end
      chk("idle_wait", 32'(bus.busy), 32'd0);
   endtask

   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit has_lit, input logic [31:0] lit);
      int n = 0;
      wait_idle();
      bus.start = 1'b1; bus.func3 = f; bus.operand_a = a; bus.operand_b = b;
      @(posedge clk); #1;
      bus.start = 1'b0; bus.operand_a = $urandom; bus.operand_b = $urandom; bus.func3 = 3'($urandom);
      while (bus.done !== 1'b1 && n < 100) begin
         @(posedge clk); #1; n++;
      end
      chk("latency", 32'(n), model_fast(f, a, b) ? 32'd1 : 32'(W));
      if (has_lit) chk("literal_result", bus.result, lit);
   endtask

   typedef struct {
      logic [2:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e;
   } vec_t;

   vec_t tbl[14] = '{
      '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
      '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000},
      '{3'd4, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFA},
      '{3'd6, 32'hFFFF_FFEC,  32'd3,         32'hFFFF_FFFE},
      '{3'd5, 32'd20,         32'd3,         32'h0000_0006},
      '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF},
      '{3'd6, 32'd5,          32'd0,         32'h0000_0005},
      '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
      '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000},
      '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
      '{3'd7, 32'd100,        32'd7,         32'h0000_0002},
      '{3'd0, 32'd0,          32'd12345,     32'h0000_0000},
      '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000}
   };

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'd1;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dones;
      int gap;
      int n;
      bus.start = 1'b0; bus.func3 = '0; bus.operand_a = '0; bus.operand_b = '0;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(bus.busy), 32'd0);
      chk("reset_done", 32'(bus.done), 32'd0);
      chk("reset_result", bus.result, 32'd0);
      reset = 1'b0;

      foreach (tbl[i]) begin
         chk("model_pin", model_result(tbl[i].f, tbl[i].a, tbl[i].b), tbl[i].e);
         run_op(tbl[i].f, tbl[i].a, tbl[i].b, 1'b1, tbl[i].e);
      end

      // Reset in the middle of a divide.
      wait_idle();
      bus.start = 1'b1; bus.func3 = 3'd4; bus.operand_a = 32'd1000; bus.operand_b = 32'd7;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) begin @(posedge clk); #1; end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("midop_reset_busy", 32'(bus.busy), 32'd0);
      chk("midop_reset_done", 32'(bus.done), 32'd0);
      chk("midop_reset_result", bus.result, 32'd0);
      run_op(3'd0, 32'd6, 32'd7, 1'b1, 32'h0000_002A);

      // Start coinciding with reset is ignored; the first clean edge accepts it.
      wait_idle();
      reset = 1'b1; bus.start = 1'b1; bus.func3 = 3'd0; bus.operand_a = 32'd3; bus.operand_b = 32'd3;
      @(posedge clk); #1;
      chk("start_under_reset", 32'(bus.busy), 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("start_after_reset", 32'(bus.busy), 32'd1);
      bus.start = 1'b0;
      wait_idle();

      // Start held high across two operations.
      bus.start = 1'b1; bus.func3 = 3'd0; bus.operand_a = 32'd6; bus.operand_b = 32'd7;
      @(posedge clk); #1;
      bus.func3 = 3'd5; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
      dones = 0; gap = 0; n = 0;
      while (dones < 2 && n < 3 * W) begin
         @(posedge clk); #1; n++;
         if (dones == 1) gap++;
         if (bus.done === 1'b1) begin
            dones++;
            if (dones == 1) chk("b2b_first", bus.result, 32'h0000_002A);
         end
      end
      bus.start = 1'b0;
      chk("b2b_dones", 32'(dones), 32'd2);
      chk("b2b_gap", 32'(gap), 32'(W + 2));
      chk("b2b_second", bus.result, 32'h0000_000E);

      for (int k = 0; k < 40; k++) begin
         run_op(3'($urandom_range(0, 7)), pick(), pick(), 1'b0, 32'd0);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wait_idle();
      repeat (2) @(posedge clk);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/mdu_sequencer.md
MDU_SEQUENCER -- requirements
Module: mdu_sequencer

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; iteration count equals WIDTH.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin an operation; sampled only while busy=0.
REQ-005 func3  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 operand_a  input  WIDTH  rs1 value (multiplicand/dividend).
REQ-007 operand_b  input  WIDTH  rs2 value (multiplier/divisor).
REQ-008 busy  output  1  high while an accepted operation is in progress, including the done cycle.
REQ-009 done  output  1  single-cycle pulse; result valid in that cycle.
REQ-010 result  output  WIDTH  operation result; held stable from done until the next accepted start.

Function
REQ-011 FSM states SHALL be IDLE, MUL, DIV, FINISH; busy=1 in MUL, DIV and FINISH.
REQ-012 IDLE + start=1: latch func3 and operands, compute operand magnitudes/signs; go to MUL (func3[2]=0) or DIV (func3[2]=1); start in any other state SHALL be ignored.
REQ-013 MUL: shift-add, one multiplier bit per cycle into a 2*WIDTH accumulator; after WIDTH cycles go to FINISH.
REQ-014 DIV: restoring division, one quotient bit per cycle; after WIDTH cycles go to FINISH.
REQ-015 Iteration counter SHALL count 0..WIDTH-1 and clear on every accepted start.
REQ-016 FINISH: apply sign correction, drive result, assert done for exactly one cycle, return to IDLE next cycle.
REQ-017 Latency (no early-out): start sampled at edge N -> done high in cycle N+WIDTH+1; next start accepted in cycle N+WIDTH+2.
REQ-018 Signedness: MUL/MULH/DIV/REM both signed; MULHSU a signed, b unsigned; MULHU/DIVU/REMU both unsigned.
REQ-019 MUL returns low WIDTH product bits; MULH/MULHSU/MULHU return high WIDTH bits.
REQ-020 Signed quotient sign = sign_a XOR sign_b; signed remainder sign = sign_a.
REQ-021 Divide by zero: DIV/DIVU result all ones; REM/REMU result = operand_a.
REQ-022 Signed overflow (a = most-negative, b = -1): DIV result = a; REM result = 0.
REQ-023 done and busy SHALL never be high in IDLE; done SHALL never be high for two consecutive cycles.

Reset
REQ-024 reset=1 at any clock edge, including mid-operation: state IDLE, busy=0, done=0, result=0, counter=0, in-flight operation discarded.
REQ-025 start sampled in the same cycle as reset=1 SHALL be ignored; first start accepted at the first edge with reset=0.

Configuration
REQ-026 Macro MDU_EARLY_OUT_EN enables the early-out path.
REQ-027 Defined: divide-by-zero, signed overflow, or either multiply operand zero skip MUL/DIV, going IDLE -> FINISH directly (done at cycle N+2).
REQ-028 Undefined: every operation runs the full WIDTH iterations; results SHALL be bit-identical to the defined case.

Verification
REQ-029 WIDTH=32, MUL a=7, b=-3 (0xFFFFFFFD) -> done at N+33, result=0xFFFFFFEB.
REQ-030 MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-031 DIV a=-20, b=3 -> 0xFFFFFFFA; REM same -> 0xFFFFFFFE; DIVU a=20, b=3 -> 0x00000006.
REQ-032 DIV a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 0x00000005; DIV a=0x80000000, b=-1 -> 0x80000000; done at N+2 with MDU_EARLY_OUT_EN, N+33 without.
REQ-033 reset pulsed at iteration 10 of a DIV -> busy=0, done=0, result=0 next cycle; fresh MUL 6x7 then returns 0x0000002A with no stale state.
REQ-034 start held high continuously across two operations -> second op accepted only in the cycle after FINISH; done pulses exactly once per op.
